// File: rtl/servant_uart_tx_if.sv
// Wishbone slave bundle between the servant ext bus and the UART transmitter.
// The master drives the request side, and the slave returns the read data and the acknowledge.
interface servant_uart_tx_if;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_uart_tx.sv
// Wishbone UART transmitter: byte FIFO feeding an 8N1 serialiser with a programmable baud divider.
// The interrupt is raised when the transmitter has fully drained.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for div cycles
// DATA  | eight data bits, LSB first, div cycles each
// STOP  | stop bit (high) for div cycles, then chain or idle
module servant_uart_tx #(
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    servant_uart_tx_if.slave   wb,
    output logic               o_tx,
    output logic               o_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nx;
    logic [15:0]    cnt, cnt_nx;
    logic [2:0]     bit_idx, bit_nx;
    logic [7:0]     shift, shift_nx;
    logic [15:0]    div_lat, div_lat_nx;
    logic           tx_q, tx_nx;
    logic           pop;

    logic [15:0]    div;
    logic           irq_en;
    logic           overflow;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  count;

    logic           access, wr, push_req, push_ok, full, empty;
    logic [15:0]    div_eff;
    logic [31:0]    status, rd_val;
    logic           unused_ok;

    assign access   = wb.cyc & ~wb.ack;
    assign wr       = access & wb.we;
    assign push_req = wr & (wb.adr == 2'd0) & wb.sel[0];
    assign full     = (count == LW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req & (~full | pop);
    assign div_eff  = (div == 16'd0) ? 16'd1 : div;
    assign unused_ok = &{1'b0, wb.dat[31:16], wb.sel[3:2]};

    always_comb begin
        status = '0;
        status[0] = (state != IDLE);
        status[1] = full;
        status[2] = empty;
        status[3] = overflow;
        status[8 +: LW] = count;
    end

    always_comb begin
        rd_val = '0;
        case (wb.adr)
            2'd1:    rd_val = status;
            2'd2:    rd_val = {16'd0, div};
            2'd3:    rd_val = {31'd0, irq_en};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb.ack   <= 1'b0;
            wb.rdt   <= '0;
            div      <= DEFAULT_DIV;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wb.ack <= access;
            wb.rdt <= access ? rd_val : 32'd0;
            if (wr && wb.adr == 2'd2) begin
                if (wb.sel[0]) div[7:0]  <= wb.dat[7:0];
                if (wb.sel[1]) div[15:8] <= wb.dat[15:8];
            end
            if (wr && wb.adr == 2'd3 && wb.sel[0]) irq_en <= wb.dat[0];
            if (wr && wb.adr == 2'd1)
                overflow <= 1'b0;
            else if (push_req && !push_ok)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= wb.dat[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_nx     = bit_idx;
        shift_nx   = shift;
        div_lat_nx = div_lat;
        tx_nx      = tx_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_nx   = mem[rd_ptr];
                    div_lat_nx = div_eff;
                    cnt_nx     = div_eff - 16'd1;
                    tx_nx      = 1'b0;
                    state_nx   = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_nx = DATA;
                    bit_nx   = 3'd0;
                    tx_nx    = shift[0];
                    shift_nx = {1'b0, shift[7:1]};
                    cnt_nx   = div_lat - 16'd1;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_nx = div_lat - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_nx   = bit_idx + 3'd1;
                        tx_nx    = shift[0];
                        shift_nx = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end else if (!empty) begin
                    // Chain straight into the next start bit with no idle gap.
                    pop        = 1'b1;
                    shift_nx   = mem[rd_ptr];
                    div_lat_nx = div_eff;
                    cnt_nx     = div_eff - 16'd1;
                    tx_nx      = 1'b0;
                    state_nx   = START;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            div_lat <= 16'd1;
            tx_q    <= 1'b1;
            o_irq   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
            div_lat <= div_lat_nx;
            tx_q    <= tx_nx;
            o_irq   <= irq_en & empty & (state == IDLE);
        end
    end

    assign o_tx = tx_q;
endmodule

// File: tb/tb_servant_uart_tx.sv
// Scoreboarded bench for servant_uart_tx: queued bytes are checked by a line monitor that decodes 8N1 frames.
// Register reads, overflow, interrupt timing and asynchronous reset are checked directly.
module tb_servant_uart_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, irq;
    always #5 clk = ~clk;

    servant_uart_tx_if bus();

    servant_uart_tx #(.DEFAULT_DIV(16'd868), .FIFO_DEPTH(8)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .wb     (bus.slave),
        .o_tx   (tx),
        .o_irq  (irq)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int model_div = 868;
    logic [7:0] exp_q[$];
    int start_q[$];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: every sample of a frame must match the ideal 8N1 waveform for the expected byte.
    logic       in_frame = 1'b0;
    int         pos, fdiv, errs;
    logic [9:0] fbits;
    logic [7:0] fbyte;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                fdiv = (model_div == 0) ? 1 : model_div;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: frame started at cycle %0d, expected none", cycle);
                    fbyte = 8'h00;
                end else begin
                    fbyte = exp_q.pop_front();
                end
                fbits = {1'b1, fbyte, 1'b0};
                start_q.push_back(cycle);
                in_frame = 1'b1;
                pos = 0;
                errs = 0;
            end
            if (in_frame) begin
                if (tx !== fbits[pos / fdiv]) errs++;
                pos++;
                if (pos == 10 * fdiv) begin
                    check($sformatf("frame_0x%02h_div%0d_bad_samples", fbyte, fdiv), errs, 0);
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        @(negedge clk);
        bus.adr = a; bus.we = w; bus.dat = d; bus.sel = s; bus.cyc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.ack) break;
        end
        if (!bus.ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_ack_timeout: got no ack, expected ack within 8 cycles");
        end
        r = bus.rdt;
        bus.cyc = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(a, 1'b1, d, s, r);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        wb_xfer(a, 1'b0, 32'd0, 4'hF, r);
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        wr(2'd0, {24'd0, b}, 4'h1);
    endtask

    task automatic set_div(input int d);
        model_div = d;
        wr(2'd2, 32'(d), 4'h3);
    endtask

    task automatic wait_drain(input int max_reads);
        logic [31:0] r;
        bit done = 0;
        for (int i = 0; i < max_reads; i++) begin
            rd(2'd1, r);
            if (r[0] == 1'b0 && r[2] == 1'b1) begin done = 1; break; end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: status 0x%0h, expected idle and empty", r);
        end
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int k, lows;
        bus.adr = '0; bus.dat = '0; bus.sel = '0; bus.we = 1'b0; bus.cyc = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_irq", irq, 0);
        check("rst_ack", bus.ack, 0);
        @(negedge clk) rst_n = 1'b1;

        rd(2'd1, r); check("rst_status", r, 32'h0000_0004);
        rd(2'd2, r); check("rst_div", r, 868);
        rd(2'd3, r); check("rst_ctrl", r, 0);
        rd(2'd0, r); check("data_reads_zero", r, 0);
        @(posedge clk); #1;
        check("ack_single_cycle", bus.ack, 0);

        wr(2'd2, 32'h1234, 4'h3);
        wr(2'd2, 32'hABCD, 4'h1);
        rd(2'd2, r); check("div_sel0_only", r, 32'h12CD);
        wr(2'd2, 32'h5678, 4'h2);
        rd(2'd2, r); check("div_sel1_only", r, 32'h56CD);

        set_div(4);
        push(8'hA5);
        rd(2'd1, r); check("single_busy", r[0], 1);
        wait_drain(200);
        rd(2'd1, r); check("single_status_after", r, 32'h0000_0004);
        check("single_irq_disabled", irq, 0);

        set_div(2);
        start_q.delete();
        push(8'h00); push(8'hFF); push(8'h55);
        wait_drain(200);
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap_1", start_q[1] - start_q[0], 20);
            check("b2b_gap_2", start_q[2] - start_q[1], 20);
        end

        set_div(100);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (i < 9) exp_q.push_back(b);
            wr(2'd0, {24'd0, b}, 4'h1);
        end
        rd(2'd1, r); check("ovf_status", r, 32'h0000_080B);
        wr(2'd1, 32'hFFFF_FFFF, 4'hF);
        rd(2'd1, r); check("ovf_cleared", r, 32'h0000_0803);
        wait_drain(6000);
        rd(2'd1, r); check("ovf_drained", r, 32'h0000_0004);

        set_div(4);
        wr(2'd3, 32'd1, 4'h1);
        rd(2'd3, r); check("ctrl_readback", r, 1);
        repeat (2) @(negedge clk);
        check("irq_idle_enabled", irq, 1);
        push(8'h41);
        k = 0;
        while (k < 20 && tx !== 1'b0) begin @(negedge clk); k++; end
        check("irq_frame_started", tx, 0);
        k = 0;
        while (k < 200 && irq !== 1'b1) begin @(negedge clk); k++; end
        check("irq_rise_latency", k, 41);
        wr(2'd3, 32'd0, 4'h1);
        repeat (2) @(negedge clk);
        check("irq_disabled", irq, 0);

        push(8'hA5);
        k = 0;
        while (k < 20 && tx !== 1'b0) begin @(negedge clk); k++; end
        repeat (17) @(negedge clk);
        check("midframe_bit3_low", tx, 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check("midframe_rst_tx", tx, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_div = 868;
        rd(2'd1, r); check("midframe_status", r, 32'h0000_0004);
        rd(2'd2, r); check("midframe_div", r, 868);
        lows = 0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        check("midframe_no_residual", lows, 0);

        for (int round = 0; round < 6; round++) begin
            int n;
            set_div((round == 0) ? 0 : int'($urandom_range(1, 6)));
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                push(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 15)) @(posedge clk);
            end
            wait_drain(500);
            rd(2'd1, r); check($sformatf("rand_round%0d_status", round), r, 32'h0000_0004);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
